// File: rtl/cdb_pkg.sv
// cdb_pkg: shared default sizes, CDB entry type and popcount helper for the CDB broadcast queue
package cdb_pkg;
  localparam int NUM_FU_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TAG_WIDTH_DEF = 7;
  localparam int DEPTH_DEF = 8;
  typedef struct packed {
    logic [TAG_WIDTH_DEF-1:0] tag;
    logic [DATA_WIDTH_DEF-1:0] data;
  } cdb_entry_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount = popcount + {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/cdb_accept_select.sv
// cdb_accept_select: rotation-priority acceptance of unit completions limited by free queue slots, with per-unit write rank
module cdb_accept_select
  import cdb_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [RW-1:0]             rr_ptr,
  input  logic [AW:0]               free,
  output logic [NUM_FU-1:0]         queued,
  output logic [NUM_FU-1:0][AW-1:0] rank
);
  logic [AW:0] cnt;
  int k;
  always_comb begin
    queued = '0;
    rank = '0;
    cnt = '0;
    k = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      k = (int'(rr_ptr) + j) % NUM_FU;
      if (fu_done[k] && cnt < free) begin
        queued[k] = 1'b1;
        rank[k] = cnt[AW-1:0];
        cnt = cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_broadcast_queue.sv
// cdb_broadcast_queue: multi-write in-order FIFO collecting FU results and broadcasting one per cycle on the CDB (CDB_BYPASS_EN adds same-cycle bypass when empty)
module cdb_broadcast_queue
  import cdb_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  output logic [NUM_FU-1:0]            fu_queued,
  output logic                         cdb_valid,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic                         cdb_ready,
  output logic [$clog2(DEPTH):0]       occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NUM_FU);
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  entry_t head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [RW-1:0] rr_q, rr_d;
  logic [AW:0] occ_q, occ_d, free, n_wr;
  logic [NUM_FU-1:0] done, queued;
  logic [NUM_FU-1:0][AW-1:0] rank;
  logic [3:0] n_acc;
  logic pop, byp;
  assign done = rst ? '0 : fu_done;
  assign pop = (occ_q != '0) && cdb_ready && !rst;
  assign free = (AW+1)'(DEPTH) - occ_q + (AW+1)'(pop);
  cdb_accept_select #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) u_sel (
    .fu_done(done),
    .rr_ptr(rr_q),
    .free(free),
    .queued(queued),
    .rank(rank)
  );
  assign fu_queued = queued;
  assign head = mem_q[rd_q];
  assign occupancy = occ_q;
`ifdef CDB_BYPASS_EN
  entry_t byp_e;
  assign byp = (occ_q == '0) && cdb_ready && (done != '0);
  always_comb begin
    byp_e = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (queued[i] && rank[i] == '0)
        byp_e = '{tag: fu_tag[i*TAG_WIDTH +: TAG_WIDTH], data: fu_result[i*DATA_WIDTH +: DATA_WIDTH]};
  end
  assign cdb_valid = (occ_q != '0) || byp;
  assign cdb_data = (occ_q != '0) ? head.data : byp ? byp_e.data : '0;
  assign cdb_tag = (occ_q != '0) ? head.tag : byp ? byp_e.tag : '0;
`else
  assign byp = 1'b0;
  assign cdb_valid = occ_q != '0;
  assign cdb_data = cdb_valid ? head.data : '0;
  assign cdb_tag = cdb_valid ? head.tag : '0;
`endif
  assign n_acc = popcount(8'(queued));
  assign n_wr = (AW+1)'(n_acc) - (AW+1)'(byp);
  assign wr_d = wr_q + n_wr[AW-1:0];
  assign rd_d = rd_q + AW'(pop);
  assign occ_d = occ_q + n_wr - (AW+1)'(pop);
  assign rr_d = (done == '0) ? rr_q : (rr_q == RW'(NUM_FU-1)) ? '0 : rr_q + 1'b1;
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_FU; i++)
      if (queued[i] && !(byp && rank[i] == '0))
        mem_d[wr_q + rank[i] - AW'(byp)] = '{tag: fu_tag[i*TAG_WIDTH +: TAG_WIDTH], data: fu_result[i*DATA_WIDTH +: DATA_WIDTH]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      rr_q <= '0;
      occ_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      rr_q <= rr_d;
      occ_q <= occ_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: doc/cdb_broadcast_queue.md
# cdb_broadcast_queue

Receiving end of the functional-unit completion handshake: collects results (data + execution tag) from up to NUM_FU functional units and broadcasts them one per cycle on the common data bus (CDB). Each unit raises done with its result and tag; this block answers with queued in the same cycle, which releases that unit to idle. Accepted results wait in an in-order multi-write FIFO until the CDB consumer takes them.

## Interface
- NUM_FU, 4: number of functional units served (2..8)
- DATA_WIDTH, 32: result width
- TAG_WIDTH, 7: execution tag width
- DEPTH, 8: queue entries; power of two, DEPTH >= NUM_FU
- clk  in  1  single clock, rising edge
- rst  in  1  reset: synchronous, active-high
- fu_done  in  NUM_FU  per-unit completion request; bit i for unit i
- fu_result  in  NUM_FU*DATA_WIDTH  unit i result at [i*DATA_WIDTH +: DATA_WIDTH]
- fu_tag  in  NUM_FU*TAG_WIDTH  unit i execution tag at [i*TAG_WIDTH +: TAG_WIDTH]
- fu_queued  out  NUM_FU  combinational; bit i high = unit i's result accepted this cycle
- cdb_valid  out  1  head entry is presented on the CDB
- cdb_data  out  DATA_WIDTH  broadcast result
- cdb_tag  out  TAG_WIDTH  broadcast execution tag
- cdb_ready  in  1  CDB consumer takes the presented entry this cycle
- occupancy  out  $clog2(DEPTH)+1  entries currently stored

## Operation
- pop = cdb_valid & cdb_ready; free = DEPTH - occupancy + pop (a same-cycle pop frees a slot).
- Acceptance: scan units in rotation order starting at rr_ptr; each requesting unit is accepted while accepted-so-far < free. fu_queued[i] = fu_done[i] & accepted. Rejected units are not remembered; producers must hold done until queued.
- Accepted results are written at wr_ptr + k (mod DEPTH), k = rank in rotation order; wr_ptr advances by popcount(fu_queued); rd_ptr advances by pop.
- rr_ptr advances by 1 (mod NUM_FU) in every cycle with fu_done != 0.
- occupancy' = occupancy + popcount(fu_queued) - pop; never exceeds DEPTH.
- cdb_valid = occupancy != 0; cdb_data/cdb_tag show the head entry, forced to 0 when cdb_valid is 0.
- Ordering: strict FIFO; within one cycle, rotation order.
- During rst: fu_queued all 0, no writes or pops.

## Timing
- Reset values: cdb_valid 0, cdb_data 0, cdb_tag 0, occupancy 0, fu_queued 0; rd_ptr, wr_ptr, rr_ptr 0.
- Latency (default build): done in cycle N -> earliest cdb_valid in cycle N+1.
- Combinational paths: fu_done -> fu_queued, and cdb_ready -> fu_queued (via free). No path from fu_* to cdb_* without CDB_BYPASS_EN.
- Full with cdb_ready high: one slot frees; exactly one requester (first in rotation) is accepted.
- Full with cdb_ready low: all requests rejected; state unchanged except rr_ptr.
- Pointer wrap: pointers are $clog2(DEPTH) bits, wrap naturally; full/empty from occupancy only.
- rst mid-operation: all stored entries discarded next edge; in-flight done pulses during rst are not queued.

## Configuration
- CDB_BYPASS_EN defined: when occupancy == 0 and cdb_ready == 1, the first requester in rotation order is driven directly onto cdb_data/cdb_tag with cdb_valid high in the same cycle, gets fu_queued, and is not written; other requesters follow normal acceptance. Latency becomes 0 in that case.
- Undefined: no bypass; cdb_* are functions of stored state only.

## Structure
- Package cdb_pkg: cdb_entry_t {tag, data} struct, default DATA_WIDTH/TAG_WIDTH/NUM_FU/DEPTH constants, popcount function.
- Sub-module cdb_accept_select: rotation-priority acceptance, computes fu_queued and per-unit write rank from fu_done, rr_ptr, free. Storage, pointers and CDB output stay in the top.

## Test plan
- Reset, single request: unit 1 done (data 0x0000_0005, tag 0x12), cdb_ready 1 -> fu_queued=0010 same cycle; next cycle cdb_valid 1, data 5, tag 0x12; then occupancy 0.
- Four simultaneous dones, rr_ptr 2, cdb_ready 0 -> fu_queued 1111, occupancy 4; broadcast order units 2,3,0,1.
- Fill to DEPTH=8 with cdb_ready 0, then 2 requests -> fu_queued 0; same with cdb_ready 1 -> only first in rotation accepted, occupancy stays 8.
- Wrap: 20 single-unit pushes/pops with cdb_ready toggling -> tags emerge in push order, no loss or duplicate.
- rst asserted with occupancy 5 -> next cycle cdb_valid 0, occupancy 0, fu_queued 0 while rst high.
- CDB_BYPASS_EN, empty, cdb_ready 1, unit 3 done tag 0x7F -> cdb_valid same cycle with tag 0x7F, occupancy stays 0.
